// File: rtl/regfile16b_dump_reader_pkg.sv
// Shared widths and dump-FSM state encoding for the 16-bit register file and its dump reader.
package regfile16b_dump_reader_pkg;

  localparam int RF_DATA_W = 16;
  localparam int RF_ADDR_W = 3;

  typedef enum logic [1:0] {
    DUMP_IDLE = 2'd0,
    DUMP_SCAN = 2'd1,
    DUMP_LAST = 2'd2
  } dump_state_t;

endpackage

// File: rtl/regfile16b_dump_fsm.sv
// Dump sequencer: walks the register index, owns valid/busy/done, and tells the top
// when and from which index to capture the next dump_data snapshot.
module regfile16b_dump_fsm
  import regfile16b_dump_reader_pkg::*;
#(
  parameter int ADDR_W = RF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clk_en,
  input  logic              start,
  input  logic              ready,
  output logic [ADDR_W-1:0] idx,
  output logic [ADDR_W-1:0] load_idx,
  output logic              load,
  output logic              valid,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W-1:0] LAST_IDX = '1;

  dump_state_t       state_reg, state_next;
  logic [ADDR_W-1:0] idx_reg, idx_next;
  logic              valid_reg, valid_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= DUMP_IDLE;
      idx_reg   <= '0;
      valid_reg <= 1'b0;
    end else if (clk_en) begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      valid_reg <= valid_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    valid_next = valid_reg;
    load       = 1'b0;
    load_idx   = idx_reg + 1'b1;
    case (state_reg)
      DUMP_IDLE: begin
        if (start) begin
          state_next = DUMP_SCAN;
          idx_next   = '0;
          valid_next = 1'b1;
          load       = 1'b1;
          load_idx   = '0;
        end
      end
      DUMP_SCAN: begin
        if (valid_reg && ready) begin
          if (idx_reg == LAST_IDX) begin
            valid_next = 1'b0;
            state_next = DUMP_LAST;
          end else begin
            idx_next = idx_reg + 1'b1;
            load     = 1'b1;
          end
        end
      end
      DUMP_LAST: state_next = DUMP_IDLE;
      default:   state_next = DUMP_IDLE;
    endcase
  end

  assign idx   = idx_reg;
  assign valid = valid_reg;
  assign busy  = (state_reg != DUMP_IDLE);
  assign done  = (state_reg == DUMP_LAST);

endmodule

// File: rtl/regfile16b_dump_reader.sv
// 8 x 16-bit register file with write-first combinational read ports and a
// valid/ready dump stream that snapshots each register as it is offered.
module regfile16b_dump_reader
  import regfile16b_dump_reader_pkg::*;
#(
  parameter int DATA_W  = RF_DATA_W,
  parameter int ADDR_W  = RF_ADDR_W,
  parameter bit R0_ZERO = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clk_en,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr_a,
  output logic [DATA_W-1:0] rdata_a,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [DATA_W-1:0] rdata_b,
  input  logic              dump_start,
  output logic              dump_busy,
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic [ADDR_W-1:0] dump_addr,
  output logic [DATA_W-1:0] dump_data,
  output logic              dump_done
);

  localparam int NREG = 1 << ADDR_W;

  logic [DATA_W-1:0] regs [NREG];
  logic [DATA_W-1:0] byp  [NREG];
  logic              wr_legal;
  logic              load;
  logic [ADDR_W-1:0] load_idx;

  assign wr_legal = clk_en & we & ~(R0_ZERO & (waddr == '0));

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (wr_legal) begin
      regs[waddr] <= wdata;
    end
  end

  // Write-first view of every register; shared by both read ports and the dump capture.
  for (genvar gi = 0; gi < NREG; gi++) begin : g_byp
    assign byp[gi] = (wr_legal && (waddr == ADDR_W'(gi))) ? wdata :
                     ((R0_ZERO && gi == 0) ? '0 : regs[gi]);
  end

  assign rdata_a = byp[raddr_a];
  assign rdata_b = byp[raddr_b];

  // Snapshot taken only when a new beat is loaded, so later writes to the offered index
  // never disturb a beat that is waiting for ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      dump_data <= '0;
    end else if (clk_en && load) begin
      dump_data <= byp[load_idx];
    end
  end

  regfile16b_dump_fsm #(
    .ADDR_W(ADDR_W)
  ) u_fsm (
    .clk     (clk),
    .rst     (rst),
    .clk_en  (clk_en),
    .start   (dump_start),
    .ready   (dump_ready),
    .idx     (dump_addr),
    .load_idx(load_idx),
    .load    (load),
    .valid   (dump_valid),
    .busy    (dump_busy),
    .done    (dump_done)
  );

endmodule
